// File: rtl/edge_event_pkg.sv
// Shared types and constants for the edge event arbiter.
package edge_event_pkg;

   typedef enum logic [1:0] {EM_OFF, EM_RISE, EM_FALL, EM_BOTH} edge_mode_t;

   typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

   localparam logic EVT_RISE = 1'b1;
   localparam logic EVT_FALL = 1'b0;

endpackage

// File: rtl/edge_chan.sv
// Per-channel edge detector: registered one-cycle rise/fall pulses.
module edge_chan (
   input  logic clk,
   input  logic rst,
   input  logic sig,
   output logic rise_p,
   output logic fall_p
);

   logic prev;

   // prev resets low so a signal already high after reset reads as a rise
   always_ff @(posedge clk) begin
      if (rst) begin
         prev   <= 1'b0;
         rise_p <= 1'b0;
         fall_p <= 1'b0;
      end else begin
         prev   <= sig;
         rise_p <= sig & ~prev;
         fall_p <= ~sig & prev;
      end
   end

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge event scheduler with round-robin valid/ready output.
// Optional sticky drop flags: define EDGE_EVENT_ARBITER_OVF_EN.
module edge_event_arbiter
   import edge_event_pkg::*;
#(
   parameter  int unsigned N_CH = 4,
   localparam int unsigned IDW  = $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              rst,
`ifdef EDGE_EVENT_ARBITER_OVF_EN
   input  logic [N_CH-1:0]   ovf_clr,
   output logic [N_CH-1:0]   ovf,
`endif
   input  logic [N_CH-1:0]   sig_in,
   input  logic [2*N_CH-1:0] mode_cfg,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [IDW-1:0]    evt_ch,
   output logic              evt_kind,
   output logic [N_CH-1:0]   pending
);

   logic [N_CH-1:0] rise_p;
   logic [N_CH-1:0] fall_p;
   logic [N_CH-1:0] gated;
   logic [N_CH-1:0] kind;
   logic [N_CH-1:0] kind_nxt;
   logic [N_CH-1:0] gnt_vec;
   logic [N_CH-1:0] keep;
   logic [N_CH-1:0] set_vec;
   logic [N_CH-1:0] pend_nxt;
   logic [IDW-1:0]  rr_ptr;
   logic [IDW-1:0]  grant_ch;
   logic            grant_c;
   arb_state_t      state;
   arb_state_t      state_nxt;

   // First requesting channel at or after ptr, wrapping around
   function automatic logic [IDW-1:0] rr_pick(input logic [N_CH-1:0] req,
                                              input logic [IDW-1:0]  ptr);
      logic [IDW-1:0] sel;
      logic [IDW-1:0] cand;
      logic           found;
      int unsigned    idx;
      sel   = '0;
      found = 1'b0;
      for (int unsigned off = 0; off < N_CH; off++) begin
         idx  = (32'(ptr) + off) % N_CH;
         cand = IDW'(idx);
         if (!found && req[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
      return sel;
   endfunction

   for (genvar g = 0; g < N_CH; g++) begin : g_chan
      edge_mode_t mode;

      edge_chan u_chan (
         .clk    (clk),
         .rst    (rst),
         .sig    (sig_in[g]),
         .rise_p (rise_p[g]),
         .fall_p (fall_p[g])
      );

      assign mode     = edge_mode_t'(mode_cfg[2*g +: 2]);
      assign gated[g] = (rise_p[g] && (mode == EM_RISE || mode == EM_BOTH)) ||
                        (fall_p[g] && (mode == EM_FALL || mode == EM_BOTH));
      assign kind_nxt[g] = set_vec[g] ? (rise_p[g] ? EVT_RISE : EVT_FALL) : kind[g];
   end

   // Grant decision: on entry from idle, or back-to-back on a handshake
   always_comb begin
      state_nxt = state;
      grant_c   = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (|pending) begin
               grant_c   = 1'b1;
               state_nxt = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            if (evt_ready) begin
               if (|pending) grant_c   = 1'b1;
               else          state_nxt = ARB_IDLE;
            end
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   // A new pulse on a held (not granted) channel is dropped; on a granted one it re-arms
   assign grant_ch = rr_pick(pending, rr_ptr);
   assign gnt_vec  = grant_c ? (N_CH'(1) << grant_ch) : '0;
   assign keep     = pending & ~gnt_vec;
   assign set_vec  = gated & ~keep;
   assign pend_nxt = keep | set_vec;

   always_ff @(posedge clk) begin
      if (rst) state <= ARB_IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         evt_valid <= 1'b0;
         evt_ch    <= '0;
         evt_kind  <= 1'b0;
         pending   <= '0;
         kind      <= '0;
         rr_ptr    <= '0;
      end else begin
         evt_valid <= (state_nxt == ARB_BUSY);
         pending   <= pend_nxt;
         kind      <= kind_nxt;
         if (grant_c) begin
            evt_ch   <= grant_ch;
            evt_kind <= kind[grant_ch];
            rr_ptr   <= (grant_ch == IDW'(N_CH - 1)) ? '0 : grant_ch + IDW'(1);
         end
      end
   end

`ifdef EDGE_EVENT_ARBITER_OVF_EN
   logic [N_CH-1:0] drop;

   assign drop = gated & keep;

   always_ff @(posedge clk) begin
      if (rst) ovf <= '0;
      else     ovf <= (ovf & ~ovf_clr) | drop;
   end
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench for edge_event_arbiter: vector table plus corner-case sequences.
module tb_edge_event_arbiter;

   localparam int unsigned N_CH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] sig_in;
   logic [7:0] mode_cfg;
   logic       evt_valid;
   logic       evt_ready;
   logic [1:0] evt_ch;
   logic       evt_kind;
   logic [3:0] pending;
`ifdef EDGE_EVENT_ARBITER_OVF_EN
   logic [3:0] ovf_clr;
   logic [3:0] ovf;
`endif

   edge_event_arbiter #(.N_CH(N_CH)) dut (
      .clk       (clk),
      .rst       (rst),
`ifdef EDGE_EVENT_ARBITER_OVF_EN
      .ovf_clr   (ovf_clr),
      .ovf       (ovf),
`endif
      .sig_in    (sig_in),
      .mode_cfg  (mode_cfg),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_ch    (evt_ch),
      .evt_kind  (evt_kind),
      .pending   (pending)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] ch;
      logic       kind;
   } exp_evt_t;

   typedef struct {
      logic       rst;
      logic [3:0] sig;
      logic [7:0] mode;
      logic       rdy;
      logic       v;
      logic [1:0] ch;
      logic       k;
      logic [3:0] p;
      logic       ck;
   } vec_t;

   exp_evt_t sb[$];
   vec_t     vecs[$];
   int       errors = 0;
   int       checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk(input string tag, input logic v, input logic [1:0] ch, input logic k,
                      input logic [3:0] p, input logic ck);
      check({tag, ".valid"}, 32'(evt_valid), 32'(v));
      check({tag, ".pending"}, 32'(pending), 32'(p));
      if (ck) begin
         check({tag, ".ch"}, 32'(evt_ch), 32'(ch));
         check({tag, ".kind"}, 32'(evt_kind), 32'(k));
      end
   endtask

   // Handshakes that will complete at the coming edge are scored against the queue
   task automatic step();
      exp_evt_t e;
      if (evt_valid === 1'b1 && evt_ready === 1'b1 && rst === 1'b0) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL hs_unexpected: got ch%0d kind%0d, none expected", evt_ch, evt_kind);
         end else begin
            e = sb.pop_front();
            check("hs_ch", 32'(evt_ch), 32'(e.ch));
            check("hs_kind", 32'(evt_kind), 32'(e.kind));
         end
      end
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic r, input logic [3:0] s, input logic [7:0] m,
                               input logic rd, input logic v, input logic [1:0] ch,
                               input logic k, input logic [3:0] p, input logic ck);
      vec_t x;
      x.rst = r; x.sig = s; x.mode = m; x.rdy = rd;
      x.v = v; x.ch = ch; x.k = k; x.p = p; x.ck = ck;
      return x;
   endfunction

   function automatic exp_evt_t ev(input logic [1:0] ch, input logic k);
      exp_evt_t e;
      e.ch = ch;
      e.kind = k;
      return e;
   endfunction

   initial begin
      rst = 1'b1; sig_in = '0; mode_cfg = 8'h55; evt_ready = 1'b1;
`ifdef EDGE_EVENT_ARBITER_OVF_EN
      ovf_clr = '0;
`endif
      // reset, held-high ch0 gives one rise event three edges after release
      vecs.push_back(mk(1, 4'b0001, 8'h55, 1, 0, 0, 0, 4'b0000, 1));
      vecs.push_back(mk(1, 4'b0001, 8'h55, 1, 0, 0, 0, 4'b0000, 1));
      vecs.push_back(mk(0, 4'b0001, 8'h55, 1, 0, 0, 0, 4'b0000, 0));
      vecs.push_back(mk(0, 4'b0001, 8'h55, 1, 0, 0, 0, 4'b0001, 0));
      vecs.push_back(mk(0, 4'b0001, 8'h55, 1, 1, 0, 1, 4'b0000, 1));
      vecs.push_back(mk(0, 4'b0001, 8'h55, 1, 0, 0, 0, 4'b0000, 0));
      vecs.push_back(mk(0, 4'b0001, 8'h55, 1, 0, 0, 0, 4'b0000, 0));
      // ch2 both-edges pulse: rise then fall back-to-back, re-arm while granted
      vecs.push_back(mk(0, 4'b0101, 8'h30, 1, 0, 0, 0, 4'b0000, 0));
      vecs.push_back(mk(0, 4'b0001, 8'h30, 1, 0, 0, 0, 4'b0100, 0));
      vecs.push_back(mk(0, 4'b0001, 8'h30, 1, 1, 2, 1, 4'b0100, 1));
      vecs.push_back(mk(0, 4'b0001, 8'h30, 1, 1, 2, 0, 4'b0000, 1));
      vecs.push_back(mk(0, 4'b0001, 8'h30, 1, 0, 0, 0, 4'b0000, 0));
      // fresh reset, all four rise together, then ch0+ch3 confirm pointer wrapped to 0
      vecs.push_back(mk(1, 4'b0000, 8'h55, 1, 0, 0, 0, 4'b0000, 1));
      vecs.push_back(mk(0, 4'b0000, 8'h55, 1, 0, 0, 0, 4'b0000, 0));
      vecs.push_back(mk(0, 4'b1111, 8'h55, 1, 0, 0, 0, 4'b0000, 0));
      vecs.push_back(mk(0, 4'b1111, 8'h55, 1, 0, 0, 0, 4'b1111, 0));
      vecs.push_back(mk(0, 4'b1111, 8'h55, 1, 1, 0, 1, 4'b1110, 1));
      vecs.push_back(mk(0, 4'b1111, 8'h55, 1, 1, 1, 1, 4'b1100, 1));
      vecs.push_back(mk(0, 4'b1111, 8'h55, 1, 1, 2, 1, 4'b1000, 1));
      vecs.push_back(mk(0, 4'b1111, 8'h55, 1, 1, 3, 1, 4'b0000, 1));
      vecs.push_back(mk(0, 4'b1111, 8'h55, 1, 0, 0, 0, 4'b0000, 0));
      vecs.push_back(mk(0, 4'b0000, 8'h55, 1, 0, 0, 0, 4'b0000, 0));
      vecs.push_back(mk(0, 4'b0000, 8'h55, 1, 0, 0, 0, 4'b0000, 0));
      vecs.push_back(mk(0, 4'b1001, 8'h55, 1, 0, 0, 0, 4'b0000, 0));
      vecs.push_back(mk(0, 4'b1001, 8'h55, 1, 0, 0, 0, 4'b1001, 0));
      vecs.push_back(mk(0, 4'b1001, 8'h55, 1, 1, 0, 1, 4'b1000, 1));
      vecs.push_back(mk(0, 4'b1001, 8'h55, 1, 1, 3, 1, 4'b0000, 1));
      vecs.push_back(mk(0, 4'b1001, 8'h55, 1, 0, 0, 0, 4'b0000, 0));

      sb.push_back(ev(0, 1));
      sb.push_back(ev(2, 1)); sb.push_back(ev(2, 0));
      for (int c = 0; c < 4; c++) sb.push_back(ev(2'(c), 1));
      sb.push_back(ev(0, 1)); sb.push_back(ev(3, 1));

      for (int i = 0; i < vecs.size(); i++) begin
         rst = vecs[i].rst; sig_in = vecs[i].sig;
         mode_cfg = vecs[i].mode; evt_ready = vecs[i].rdy;
         step();
         chk($sformatf("vec%0d", i), vecs[i].v, vecs[i].ch, vecs[i].k, vecs[i].p, vecs[i].ck);
      end

      // stall: ch1 held for five cycles while ch3 queues behind it
      sig_in = 4'b0000;
      for (int n = 0; n < 3; n++) step();
      evt_ready = 1'b0; sig_in = 4'b0010;
      step(); chk("stall_c0", 0, 0, 0, 4'b0000, 0);
      step(); chk("stall_c1", 0, 0, 0, 4'b0010, 0);
      sb.push_back(ev(1, 1));
      step(); chk("stall_c2", 1, 1, 1, 4'b0000, 1);
      sig_in = 4'b1010;
      for (int n = 0; n < 4; n++) begin
         step();
         chk($sformatf("stall_hold%0d", n), 1, 1, 1, (n == 0) ? 4'b0000 : 4'b1000, 1);
      end
      evt_ready = 1'b1; sb.push_back(ev(3, 1));
      step(); chk("stall_next", 1, 3, 1, 4'b0000, 1);
      step(); chk("stall_idle", 0, 0, 0, 4'b0000, 0);

      // drop: second ch0 edge while ch0 waits behind stalled ch1
      sig_in = 4'b0000;
      for (int n = 0; n < 3; n++) step();
      mode_cfg = 8'h07; evt_ready = 1'b0; sig_in = 4'b0010;
      step(); step();
      sb.push_back(ev(1, 1));
      step(); chk("drop_ch1", 1, 1, 1, 4'b0000, 1);
      sig_in = 4'b0011;
      step(); step(); chk("drop_pend", 1, 1, 1, 4'b0001, 1);
      sig_in = 4'b0010;
      step();
`ifdef EDGE_EVENT_ARBITER_OVF_EN
      check("ovf_pre", 32'(ovf), 32'h0);
`endif
      step(); chk("drop_kept", 1, 1, 1, 4'b0001, 1);
`ifdef EDGE_EVENT_ARBITER_OVF_EN
      check("ovf_set", 32'(ovf), 32'h1);
      step(); check("ovf_sticky", 32'(ovf), 32'h1);
      ovf_clr = 4'b0001;
      step(); check("ovf_clr", 32'(ovf), 32'h0);
      ovf_clr = 4'b0000;
`endif
      evt_ready = 1'b1; sb.push_back(ev(0, 1));
      step(); chk("drop_ch0", 1, 0, 1, 4'b0000, 1);
      for (int n = 0; n < 3; n++) begin
         step(); chk($sformatf("drop_quiet%0d", n), 0, 0, 0, 4'b0000, 0);
      end

      // reset while presenting: event discarded, held-high lines re-fire after release
      mode_cfg = 8'h55; sig_in = 4'b0000;
      for (int n = 0; n < 3; n++) step();
      evt_ready = 1'b0; sig_in = 4'b0100;
      step(); step();
      step(); chk("rst_pre", 1, 2, 1, 4'b0000, 1);
      sig_in = 4'b1100;
      step(); step(); chk("rst_pre_pend", 1, 2, 1, 4'b1000, 1);
      rst = 1'b1;
      step(); chk("rst_mid", 0, 0, 0, 4'b0000, 1);
      rst = 1'b0; evt_ready = 1'b1;
      step(); chk("rst_f0", 0, 0, 0, 4'b0000, 0);
      step(); chk("rst_f1", 0, 0, 0, 4'b1100, 0);
      sb.push_back(ev(2, 1)); sb.push_back(ev(3, 1));
      step(); chk("rst_f2", 1, 2, 1, 4'b1000, 1);
      step(); chk("rst_f3", 1, 3, 1, 4'b0000, 1);
      step(); chk("rst_f4", 0, 0, 0, 4'b0000, 0);

      check("sb_empty", 32'(sb.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
